// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - shared constants, opcodes and FSM state type for the ALU command receiver
package alu_mc_pkg;

    localparam int FRAME_BITS = 10;

    localparam logic [3:0] OP_CMP     = 4'd0;
    localparam logic [3:0] OP_NOR     = 4'd1;
    localparam logic [3:0] OP_DIV     = 4'd2;
    localparam logic [3:0] OP_OR      = 4'd3;
    localparam logic [3:0] OP_MUL     = 4'd4;
    localparam logic [3:0] OP_NAND    = 4'd5;
    localparam logic [3:0] OP_ADD_HI  = 4'd6;
    localparam logic [3:0] OP_AND     = 4'd7;
    localparam logic [3:0] OP_CARRY0  = 4'd8;
    localparam logic [3:0] OP_NOT_B1  = 4'd9;
    localparam logic [3:0] OP_SUM0    = 4'd10;
    localparam logic [3:0] OP_NOT_A1  = 4'd11;
    localparam logic [3:0] OP_XNOR    = 4'd12;
    localparam logic [3:0] OP_NOT_B0  = 4'd13;
    localparam logic [3:0] OP_XOR     = 4'd14;
    localparam logic [3:0] OP_NOT_A0  = 4'd15;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_LENGTH  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK
    } rx_state_t;

    // Even parity over the whole frame: a good frame XORs to zero.
    function automatic logic frame_parity_bad(input logic [FRAME_BITS-1:0] f);
        return ^f;
    endfunction

endpackage

// File: rtl/mc_sync_edge.sv
// rtl/mc_sync_edge.sv - multi-flop synchroniser with rise/fall pulse detection
module mc_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/alu_cmd_rx.sv
// rtl/alu_cmd_rx.sv - serial ALU command receiver; validated frames update the registered ALU operands
module alu_cmd_rx
    import alu_mc_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         TIMEOUT_CYC = 1024,
    parameter logic [3:0] RST_SEL     = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mcu_cs_n,
    input  logic       mcu_sclk,
    input  logic       mcu_sdi,
    output logic [3:0] sel,
    output logic       key,
    output logic [1:0] A,
    output logic [1:0] B,
    output logic       cmd_valid,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int         TO_W        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0] BIT_CNT_SAT = 4'd11;
    localparam logic [3:0] BIT_CNT_OK  = 4'(FRAME_BITS);

    logic                   sclk_rise;
    logic                   sclk_fall_unused;
    logic                   cs_rise;
    logic                   cs_fall;
    logic [SYNC_STAGES-1:0] sdi_q;
    logic                   sdi_s;

    rx_state_t              state;
    logic [FRAME_BITS-1:0]  shreg;
    logic [3:0]             bit_cnt;
    logic [TO_W-1:0]        to_cnt;

    mc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (mcu_sclk),
        .rise (sclk_rise),
        .fall (sclk_fall_unused)
    );

    mc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (mcu_cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // Same depth as the sclk path so data and its clock edge stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdi_q <= '0;
        end else begin
            sdi_q <= {sdi_q[SYNC_STAGES-2:0], mcu_sdi};
        end
    end

    assign sdi_s = sdi_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            sel       <= RST_SEL;
            key       <= 1'b0;
            A         <= 2'd0;
            B         <= 2'd0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
            busy      <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        bit_cnt <= '0;
                        to_cnt  <= '0;
                        busy    <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        shreg  <= {shreg[FRAME_BITS-2:0], sdi_s};
                        to_cnt <= '0;
                        if (bit_cnt != BIT_CNT_SAT) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                    // A bit arriving with the cs_n rise is kept, then the frame is checked.
                    if (cs_rise) begin
                        state <= ST_CHECK;
                    end else if (!sclk_rise && to_cnt == TO_LAST) begin
                        frame_err <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                    if (bit_cnt != BIT_CNT_OK) begin
                        frame_err <= 1'b1;
                        err_code  <= ERR_LENGTH;
                    end else if (frame_parity_bad(shreg)) begin
                        frame_err <= 1'b1;
                        err_code  <= ERR_PARITY;
                    end else begin
                        sel       <= shreg[9:6];
                        key       <= shreg[5];
                        A         <= shreg[4:3];
                        B         <= shreg[2:1];
                        cmd_valid <= 1'b1;
                        err_code  <= ERR_NONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
